// File: rtl/cwt_cmul_seq.sv
// Sequential Q-format complex multiplier x = a * b for one CWT bin, sharing one 32x32 multiplier
// across four partial products; one result every 5 cycles.
module cwt_cmul_seq #(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] a_re_i,
  input  logic [31:0] a_im_i,
  input  logic [31:0] b_re_i,
  input  logic [31:0] b_im_i,
  input  logic        start_i,
  output logic [31:0] x_re_o,
  output logic [31:0] x_im_o,
  output logic        start_o,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {StIdle, StPRr, StPIi, StPRi, StPIr} state_e;

  state_e             state_q;
  logic signed [31:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [63:0] acc_q;
  logic signed [64:0] re_acc_q;

  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic signed [64:0] acc_ext, prod_ext, re_diff, im_sum;

  // Arithmetic shift (floor) then clamp to the signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [64:0] v);
    logic signed [64:0] s;
    s = v >>> FRAC_BITS;
    if (!s[64] && (|s[63:31])) begin
      return 32'h7FFF_FFFF;
    end else if (s[64] && !(&s[63:31])) begin
      return 32'h8000_0000;
    end else begin
      return s[31:0];
    end
  endfunction

  // Operand select for the shared multiplier, by partial-product phase.
  always_comb begin
    mul_a = a_re_q;
    mul_b = b_re_q;
    unique case (state_q)
      StPRr:   begin mul_a = a_re_q; mul_b = b_re_q; end
      StPIi:   begin mul_a = a_im_q; mul_b = b_im_q; end
      StPRi:   begin mul_a = a_re_q; mul_b = b_im_q; end
      StPIr:   begin mul_a = a_im_q; mul_b = b_re_q; end
      default: begin mul_a = a_re_q; mul_b = b_re_q; end
    endcase
    prod     = 64'(mul_a) * 64'(mul_b);
    acc_ext  = {acc_q[63], acc_q};
    prod_ext = {prod[63], prod};
    re_diff  = acc_ext - prod_ext;
    im_sum   = acc_ext + prod_ext;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      a_re_q    <= '0;
      a_im_q    <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
      acc_q     <= '0;
      re_acc_q  <= '0;
      x_re_o    <= '0;
      x_im_o    <= '0;
      start_o   <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      start_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_re_q  <= a_re_i;
            a_im_q  <= a_im_i;
            b_re_q  <= b_re_i;
            b_im_q  <= b_im_i;
            busy_o  <= 1'b1;
            state_q <= StPRr;
          end
        end
        StPRr: begin
          acc_q   <= prod;
          state_q <= StPIi;
        end
        StPIi: begin
          re_acc_q <= re_diff;
          state_q  <= StPRi;
        end
        StPRi: begin
          acc_q   <= prod;
          state_q <= StPIr;
        end
        StPIr: begin
          x_re_o  <= sat32(re_acc_q);
          x_im_o  <= sat32(im_sum);
          start_o <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (start_i && (state_q != StIdle)) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cwt_cmul_seq.sv
// Randomized self-checking bench for cwt_cmul_seq against a wide-integer behavioural model.
module tb_cwt_cmul_seq;

  localparam int unsigned FRAC = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] a_re_i = '0, a_im_i = '0, b_re_i = '0, b_im_i = '0;
  logic        start_i = 1'b0;
  logic [31:0] x_re_o, x_im_o;
  logic        start_o, busy_o, overrun_o;

  int errors = 0;
  int checks = 0;

  cwt_cmul_seq #(.FRAC_BITS(FRAC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .a_re_i    (a_re_i),
    .a_im_i    (a_im_i),
    .b_re_i    (b_re_i),
    .b_im_i    (b_im_i),
    .start_i   (start_i),
    .x_re_o    (x_re_o),
    .x_im_o    (x_im_o),
    .start_o   (start_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic on 128-bit integers: floor shift, then clamp.
  function automatic logic [31:0] ref_sat(input logic signed [127:0] v);
    logic signed [127:0] s;
    s = v >>> FRAC;
    if (s > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -128'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] ref_re(input logic [31:0] ar, ai, br, bi);
    logic signed [127:0] xr, xi, yr, yi;
    xr = $signed(ar); xi = $signed(ai); yr = $signed(br); yi = $signed(bi);
    return ref_sat(xr * yr - xi * yi);
  endfunction

  function automatic logic [31:0] ref_im(input logic [31:0] ar, ai, br, bi);
    logic signed [127:0] xr, xi, yr, yi;
    xr = $signed(ar); xi = $signed(ai); yr = $signed(br); yi = $signed(bi);
    return ref_sat(xr * yi + xi * yr);
  endfunction

  // Model: a request occupies the unit for 4 clocks; result appears on the 4th.
  int          m_cnt;
  logic [31:0] m_re_pend, m_im_pend, m_x_re, m_x_im;
  logic        m_start, m_ovr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt <= 0; m_re_pend <= '0; m_im_pend <= '0;
      m_x_re <= '0; m_x_im <= '0; m_start <= 1'b0; m_ovr <= 1'b0;
    end else begin
      m_start <= 1'b0;
      if (m_cnt == 0) begin
        if (start_i) begin
          m_cnt     <= 4;
          m_re_pend <= ref_re(a_re_i, a_im_i, b_re_i, b_im_i);
          m_im_pend <= ref_im(a_re_i, a_im_i, b_re_i, b_im_i);
        end
      end else begin
        if (start_i) m_ovr <= 1'b1;
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_x_re <= m_re_pend; m_x_im <= m_im_pend; m_start <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("x_re", x_re_o, m_x_re);
    chk("x_im", x_im_o, m_x_im);
    chk("start_o", 32'(start_o), 32'(m_start));
    chk("busy_o", 32'(busy_o), 32'(m_cnt != 0));
    chk("overrun_o", 32'(overrun_o), 32'(m_ovr));
  end

  task automatic rand_ops();
    a_re_i = $urandom; a_im_i = $urandom; b_re_i = $urandom; b_im_i = $urandom;
  endtask

  // Called just after a rising edge; holds start for exactly one cycle.
  task automatic issue(input logic [31:0] ar, ai, br, bi);
    a_re_i = ar; a_im_i = ai; b_re_i = br; b_im_i = bi; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    rand_ops();
  endtask

  task automatic wait_result(input string name, input logic [31:0] er, input logic [31:0] ei);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (start_o) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no start_o expected pulse within 20 cycles", name);
    end else begin
      chk({name, "_re"}, x_re_o, er);
      chk({name, "_im"}, x_im_o, ei);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'(int'($urandom_range(0, 8)) - 4);
      3: return 32'(int'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rand_ops();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x_re", x_re_o, 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Pin the model itself with hand-computed values.
    chk("model_basic_re", ref_re(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
        32'hFFFB_0000);
    chk("model_trunc_re", ref_re(32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0), 32'hFFFF_FFFF);

    // Basic product, busy for 4 cycles.
    issue(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    chk("busy_c1", 32'(busy_o), 32'h1);
    wait_result("basic", 32'hFFFB_0000, 32'h000A_0000);

    issue(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h0);
    wait_result("possat", 32'h7FFF_FFFF, 32'h0);
    issue(32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0);
    wait_result("minsq", 32'h7FFF_FFFF, 32'h0);
    issue(32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h0);
    wait_result("negsat", 32'h8000_0000, 32'h0);
    issue(32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0);
    wait_result("trunc", 32'hFFFF_FFFF, 32'h0);

    // Back-to-back: second start lands in the start_o cycle of the first.
    issue(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_pulse1", 32'(start_o), 32'h1);
    chk("b2b_re1", x_re_o, 32'hFFFB_0000);
    issue(32'h0002_0000, 32'h0, 32'h0003_0000, 32'h0001_0000);
    wait_result("b2b2", 32'h0006_0000, 32'h0002_0000);
    chk("b2b_no_ovr", 32'(overrun_o), 32'h0);

    // Overrun: second request during P_II is dropped.
    issue(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    @(posedge clk); #1;
    issue(32'h0005_0000, 32'h0, 32'h0005_0000, 32'h0);
    chk("ovr_set", 32'(overrun_o), 32'h1);
    wait_result("ovr", 32'hFFFB_0000, 32'h000A_0000);
    chk("ovr_sticky", 32'(overrun_o), 32'h1);

    // Reset in the middle of an operation.
    issue(32'h0003_0000, 32'h0, 32'h0003_0000, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    chk("rst_x_re", x_re_o, 32'h0);
    chk("rst_x_im", x_im_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(32'h0002_0000, 32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000);
    wait_result("post_rst", 32'h0005_0000, 32'h0);

    // Random traffic, including dropped requests; model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      start_i = ($urandom_range(0, 3) == 0);
      a_re_i = pick(); a_im_i = pick(); b_re_i = pick(); b_im_i = pick();
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
